// File: rtl/spi_mem_responder_if.sv
// SPI pin bundle between the initiator (master) and the memory responder (slave).
interface spi_mem_responder_if;
  logic spi_clk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_clk, spi_cs_n, spi_mosi,
    input  spi_miso, spi_miso_oe
  );

  modport slave (
    input  spi_clk, spi_cs_n, spi_mosi,
    output spi_miso, spi_miso_oe
  );
endinterface

// File: rtl/spi_mem_responder.sv
// SPI mode-0 slave backed by a word array; SPI_MEM_RESPONDER_STATUS_EN adds a 0x05 status read.
// Latency: ~3 CLK from an spi_clk edge to decode/MISO update; a write commits 1 CLK after its 32nd data rise.
// Backpressure: none; the initiator paces all traffic through spi_clk, which must stay <= CLK/8.
module spi_mem_responder #(
  parameter int ADDR_BITS  = 6,
  parameter int DUMMY_BITS = 8
) (
  input  logic               CLK,
  input  logic               reset,
  spi_mem_responder_if.slave spi,
  output logic               wr_commit,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RD_DATA, S_WR_DATA, S_IGNORE
  } state_t;

  state_t               state, state_nxt;
  logic [1:0]           clk_sync, cs_sync, mosi_sync;
  logic                 clk_q, cs_q;
  logic                 rise, fall, cs_hi, cs_fall, mosi_b;
  logic [5:0]           cnt;
  logic [6:0]           cmd_sr;
  logic [7:0]           cmd_byte;
  logic                 cmd_wr;
  logic [ADDR_BITS-1:0] widx;
  logic [31:0]          wr_sr, rd_sr;
  logic                 rd_load;
  logic                 status_load;
  logic [31:0]          status_word;
  logic [31:0]          mem [2**ADDR_BITS];

  // Plain synchronizers: leaving them unreset keeps a held-low cs_n from
  // looking like a fresh falling edge once reset releases.
  always_ff @(posedge CLK) begin
    clk_sync  <= {clk_sync[0], spi.spi_clk};
    cs_sync   <= {cs_sync[0], spi.spi_cs_n};
    mosi_sync <= {mosi_sync[0], spi.spi_mosi};
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      clk_q <= 1'b0;
      cs_q  <= 1'b0;
    end else begin
      clk_q <= clk_sync[1];
      cs_q  <= cs_sync[1];
    end
  end

  assign rise     = clk_sync[1] & ~clk_q;
  assign fall     = ~clk_sync[1] & clk_q;
  assign cs_hi    = cs_sync[1];
  assign cs_fall  = cs_q & ~cs_sync[1];
  assign mosi_b   = mosi_sync[1];
  assign cmd_byte = {cmd_sr, mosi_b};

  always_ff @(posedge CLK) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (cs_fall) state_nxt = S_CMD;
      S_CMD: begin
        if (rise && cnt == 6'd7) begin
          if (cmd_byte == 8'h02 || cmd_byte == 8'h03) state_nxt = S_ADDR;
`ifdef SPI_MEM_RESPONDER_STATUS_EN
          else if (cmd_byte == 8'h05) state_nxt = S_DUMMY;
`endif
          else state_nxt = S_IGNORE;
        end
      end
      S_ADDR:    if (rise && cnt == 6'd23) state_nxt = cmd_wr ? S_WR_DATA : S_DUMMY;
      S_DUMMY:   if (rise && cnt == 6'(DUMMY_BITS - 1)) state_nxt = S_RD_DATA;
      S_RD_DATA: if (rise && cnt == 6'd31) state_nxt = S_IGNORE;
      S_WR_DATA: if (rise && cnt == 6'd31) state_nxt = S_IGNORE;
      S_IGNORE:  state_nxt = S_IGNORE;
      default:   state_nxt = S_IDLE;
    endcase
    if (cs_hi) state_nxt = S_IDLE;
  end

`ifdef SPI_MEM_RESPONDER_STATUS_EN
  logic [15:0] wr_count;
  always_ff @(posedge CLK) begin
    if (reset)          wr_count <= '0;
    else if (wr_commit) wr_count <= wr_count + 16'd1;
  end
  assign status_word = {8'hA5, 8'(ADDR_BITS), wr_count};
  assign status_load = (state == S_CMD) && (state_nxt == S_DUMMY);
`else
  assign status_word = '0;
  assign status_load = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt             <= '0;
      cmd_sr          <= '0;
      cmd_wr          <= 1'b0;
      widx            <= '0;
      wr_sr           <= '0;
      rd_sr           <= '0;
      rd_load         <= 1'b0;
      wr_commit       <= 1'b0;
      busy            <= 1'b0;
      spi.spi_miso    <= 1'b0;
      spi.spi_miso_oe <= 1'b0;
    end else begin
      busy      <= ~cs_hi;
      rd_load   <= (state == S_ADDR) && (state_nxt == S_DUMMY);
      wr_commit <= (state == S_WR_DATA) && (state_nxt == S_IGNORE);

      // Counter restarts on every state change and saturates, so it never spills into a new frame.
      if (state_nxt != state)                            cnt <= '0;
      else if (rise && state != S_IDLE && cnt != 6'h3f)  cnt <= cnt + 6'd1;

      if (state == S_CMD && rise) begin
        cmd_sr <= cmd_byte[6:0];
        if (cnt == 6'd7) cmd_wr <= (cmd_byte == 8'h02);
      end

      // Only byte-address bits above [1:0] are kept; the top of the shifter drops aliasing bits.
      if (state == S_ADDR && rise && cnt < 6'd22)
        widx <= ADDR_BITS'({widx, mosi_b});

      if (state == S_WR_DATA && rise)
        wr_sr <= {wr_sr[30:0], mosi_b};

      if (rd_load)                         rd_sr <= mem[widx];
      else if (status_load)                rd_sr <= status_word;
      else if (state == S_RD_DATA && fall) rd_sr <= {rd_sr[30:0], 1'b0};

      if (state == S_RD_DATA) begin
        if (fall) begin
          spi.spi_miso    <= rd_sr[31];
          spi.spi_miso_oe <= 1'b1;
        end
      end else begin
        spi.spi_miso    <= 1'b0;
        spi.spi_miso_oe <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_commit && !reset) mem[widx] <= wr_sr;
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder: directed SPI frames with a scoreboard-driven MISO/commit monitor.
module tb_spi_mem_responder;
  localparam int HALF = 6;

  logic CLK = 1'b0;
  logic reset;
  logic wr_commit, busy;

  spi_mem_responder_if sif ();

  spi_mem_responder #(.ADDR_BITS(6), .DUMMY_BITS(8)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .spi       (sif.slave),
    .wr_commit (wr_commit),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        oe;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   commit_cnt = 0;
  int   exp_commits = 0;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic spi_xfer(input logic [71:0] bits, input int n, input int rst_at);
    bit stop;
    stop = 1'b0;
    sif.spi_cs_n = 1'b0;
    repeat (HALF) @(negedge CLK);
    for (int i = 0; i < n && !stop; i++) begin
      if (i == rst_at) begin
        repeat (HALF) @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        check("rst_mid_miso", 33'(sif.spi_miso), 33'd0);
        check("rst_mid_oe", 33'(sif.spi_miso_oe), 33'd0);
        check("rst_mid_busy", 33'(busy), 33'd0);
        @(negedge CLK);
        reset = 1'b0;
        stop = 1'b1;
      end else begin
        sif.spi_mosi = bits[71-i];
        repeat (HALF) @(negedge CLK);
        sif.spi_clk = 1'b1;
        repeat (HALF) @(negedge CLK);
        sif.spi_clk = 1'b0;
      end
    end
    repeat (HALF) @(negedge CLK);
    sif.spi_cs_n = 1'b1;
    sif.spi_mosi = 1'b0;
    repeat (HALF) @(negedge CLK);
  endtask

  task automatic spi_wr(input logic [23:0] addr, input logic [31:0] data);
    exp_commits++;
    spi_xfer({8'h02, addr, data, 8'h00}, 64, -1);
  endtask

  task automatic spi_rd(input logic [23:0] addr, input logic [31:0] data);
    exp_q.push_back('{oe: 1'b1, word: data});
    spi_xfer({8'h03, addr, 8'h00, 32'h0}, 72, -1);
  endtask

  task automatic check_commits(input string name);
    check(name, 33'(commit_cnt), 33'(exp_commits));
  endtask

  // Sniffs each frame: decodes the command from MOSI and captures the 32-bit data window from MISO.
  initial begin : monitor
    int          rises, pre;
    logic [7:0]  cmd;
    logic [31:0] word;
    logic        oe_any, done_frame;
    exp_t        e;
    forever begin
      @(negedge sif.spi_cs_n);
      rises = 0; cmd = '0; word = '0; oe_any = 1'b0; done_frame = 1'b0; pre = 16;
      while (!done_frame) begin
        @(posedge sif.spi_clk or posedge sif.spi_cs_n);
        if (sif.spi_cs_n) begin
          done_frame = 1'b1;
        end else begin
          if (rises < 8) cmd = {cmd[6:0], sif.spi_mosi};
          oe_any = oe_any | sif.spi_miso_oe;
          pre = (cmd == 8'h03) ? 40 : 16;
          if (rises >= pre && rises < pre + 32) word = {word[30:0], sif.spi_miso};
          rises++;
        end
      end
      if (cmd != 8'h02 && rises >= pre + 32) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL rd_unexpected: got cmd %h word %h, no frame expected", cmd, word);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rd_word_cmd%h", cmd), {oe_any, word}, e);
        end
      end
    end
  end

  initial begin : commit_mon
    int width;
    width = 0;
    forever begin
      @(negedge CLK);
      if (wr_commit) begin
        width++;
      end else if (width != 0) begin
        check("commit_width", 33'(width), 33'd1);
        commit_cnt++;
        width = 0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  initial begin : stim
    sif.spi_clk  = 1'b0;
    sif.spi_cs_n = 1'b1;
    sif.spi_mosi = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge CLK);
    check("rst_miso", 33'(sif.spi_miso), 33'd0);
    check("rst_oe", 33'(sif.spi_miso_oe), 33'd0);
    check("rst_busy", 33'(busy), 33'd0);
    check("rst_commit", 33'(wr_commit), 33'd0);
    reset = 1'b0;
    repeat (4) @(negedge CLK);

    spi_wr(24'h000010, 32'hDEADBEEF);
    check_commits("commit_after_wr1");
    spi_wr(24'h000100, 32'h12345678);
    spi_wr(24'h000020, 32'h11111111);
    check_commits("commit_after_wr3");

`ifdef SPI_MEM_RESPONDER_STATUS_EN
    exp_q.push_back('{oe: 1'b1, word: 32'hA5060003});
`else
    exp_q.push_back('{oe: 1'b0, word: 32'h00000000});
`endif
    spi_xfer({8'h05, 64'h0}, 48, -1);

    spi_rd(24'h000010, 32'hDEADBEEF);
    spi_rd(24'h000000, 32'h12345678);
    spi_rd(24'h000003, 32'h12345678);

    // Aborted write: 20 of 32 data bits, then chip select released.
    spi_xfer({8'h02, 24'h000020, 32'h22222222, 8'h00}, 52, -1);
    check_commits("commit_after_abort");
    spi_rd(24'h000020, 32'h11111111);

    exp_q.push_back('{oe: 1'b0, word: 32'h00000000});
    spi_xfer({8'hFF, 64'h0}, 64, -1);
    spi_rd(24'h000010, 32'hDEADBEEF);
    check_commits("commit_after_unknown");

    // Reset lands while RD_DATA bit 12 is on the wire; this frame is dropped.
    spi_xfer({8'h03, 24'h000010, 8'h00, 32'h0}, 72, 52);
    repeat (4) @(negedge CLK);
    spi_rd(24'h000010, 32'hDEADBEEF);
    spi_rd(24'h000100, 32'h12345678);
    check_commits("commit_final");

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge CLK);
    check("scoreboard_drained", 33'(exp_q.size()), 33'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_mem_responder.md
Name: spi_mem_responder

Overview:
- SPI-slave memory model/peripheral that answers the word read/write frames issued by the processor-side SPI initiator.
- Backs the external-memory path with an on-chip word array for SoC-level integration and loopback tests.
- Oversamples the SPI pins in the system clock domain, decodes command/address, and commits or returns 32-bit words.

Parameters:
- ADDR_BITS, 6, word-index width; array depth = 2**ADDR_BITS words.
- DUMMY_BITS, 8, SPI clocks between the last address bit and the first read-data bit.

Ports:
- CLK  input  1  system clock; must be at least 8x spi_clk frequency.
- reset  input  1  synchronous, active-high reset.
- spi_clk  input  1  SPI clock from initiator, mode 0 (CPOL=0, CPHA=0).
- spi_cs_n  input  1  chip select, active low.
- spi_mosi  input  1  serial data in, MSB first.
- spi_miso  output  1  serial data out, MSB first.
- spi_miso_oe  output  1  high while this block drives read data.
- wr_commit  output  1  one-CLK pulse when a write word is stored in the array.
- busy  output  1  high while spi_cs_n is low (synchronized).

Behaviour:
- Synchronization:
  - spi_clk, spi_cs_n and spi_mosi each pass through a 2-flop synchronizer.
  - Rise and fall edges of spi_clk are detected from the synchronized copies.
  - MOSI is sampled on a detected rise. MISO changes on a detected fall.
- Frame format:
  - Command, 8 bits: 0x02 = write, 0x03 = read.
  - Byte address, 24 bits; word index = addr[ADDR_BITS+1:2].
  - Higher address bits are ignored, so addresses alias modulo the depth. Bits [1:0] are ignored.
  - Write frame: 32 data bits on MOSI follow the address.
  - Read frame: DUMMY_BITS of don't-care follow the address, then 32 data bits on MISO.
- States:
  - IDLE -> CMD when synchronized cs_n falls.
  - CMD -> ADDR after 8 bits if the command is 0x02 or 0x03; otherwise CMD -> IGNORE.
  - ADDR -> WR_DATA (write) or DUMMY (read) after 24 bits.
  - DUMMY -> RD_DATA after DUMMY_BITS rises.
  - WR_DATA -> IGNORE after 32 bits.
  - RD_DATA -> IGNORE after 32 bits.
  - IGNORE -> IDLE on cs_n high.
  - Any state -> IDLE whenever synchronized cs_n is high.
- Read:
  - The array word is read in the CLK cycle after the last address bit and loaded into a 32-bit shift register.
  - spi_miso_oe rises on the first fall detected in RD_DATA.
  - spi_miso presents bit 31 on that fall and shifts one bit per subsequent fall.
- Write:
  - On the 32nd data-bit rise, the word is written to the array in the next CLK cycle, with wr_commit high for exactly that cycle.
  - Writes are full-word only.
- Abort: cs_n high before write completion means no array write, no wr_commit, and all bit counters cleared.
- Extra SPI clocks after a complete frame are ignored (IGNORE state), and MISO is held 0.
- Unknown command: MISO held 0 with oe low, no side effects; the next frame decodes normally.
- Reset values: spi_miso=0, spi_miso_oe=0, wr_commit=0, busy=0, state IDLE, counters and shift registers 0. Array contents are not reset; simulation initializes them to 0.
- Reset asserted mid-frame: immediate return to IDLE at the next CLK edge with outputs at reset values. The block re-syncs only on the next cs_n falling edge; frames in progress are dropped.
- Bit counter: 6 bits, saturating within each state; it never wraps into a new frame.

Optional Feature:
- Macro SPI_MEM_RESPONDER_STATUS_EN.
- With the macro defined:
  - Command 0x05 is a status read: no address phase, DUMMY_BITS, then 32 bits.
  - Status word = {8'hA5, 8'(ADDR_BITS), 16-bit count of committed writes}.
  - The count wraps at 0xFFFF and is cleared by reset.
- Without the macro: 0x05 is an unknown command (IGNORE path), and no counter logic exists.

Test Plan:
- Write 0x02/0x000010/0xDEADBEEF, then read 0x03/0x000010 -> MISO returns 0xDEADBEEF; wr_commit pulses once, one CLK wide.
- Aliasing (ADDR_BITS=6): write 0x12345678 to 0x000100, read 0x000000 -> 0x12345678; read 0x000003 -> 0x12345678.
- Abort: write to 0x000020 holding 0x11111111 with cs_n raised after 20 data bits -> no wr_commit; a later read returns 0x11111111.
- Unknown command 0xFF with 64 clocks -> spi_miso=0, oe=0, no commit; an immediately following read of 0x000010 returns the correct data.
- Reset pulse during RD_DATA bit 12 -> spi_miso=0, oe=0, busy=0 next cycle; the next full read frame returns the correct word.
- With SPI_MEM_RESPONDER_STATUS_EN, after 3 writes, command 0x05 -> MISO 0xA5060003; without the macro -> MISO 0, oe low.
